data_memory: RTL
================

// Module: data_memory
// PURPOSE
//  Data memory stage directly downstream of the execute phase's memory-access unit.
//  Consumes the registered word address, the byte-lane-aligned store data and the 8-bit lane write mask.
//  Returns the full 64-bit word at that address as ld_data, exactly LOAD_LATENCY cycles later.
//  The execute phase then selects the addressed byte and width.
// PARAMETERS
//  LOAD_LATENCY  1   cycles from address presented to ld_data valid; legal range >=1
//  DEPTH_LOG2    12  log2 of the word count (DEPTH = 2**DEPTH_LOG2 words of 64 bits)
// PORTS
//  clk       in   1       single clock; all state updates on posedge
//  rstn      in   1       reset: asynchronous assert, active-low
//  mem_addr  in   ADDR_W  word index (byte address >> 3)
//  st_data   in   REG_W   store data, already shifted to its byte lanes
//  we        in   8       per-byte-lane write enable; bit k covers st_data[8k+7:8k]
//  ld_data   out  REG_W   64-bit word read LOAD_LATENCY cycles earlier
//  addr_err  out  1       high in the same cycle as the ld_data of an out-of-range access
//  busy      out  1       high while memory is unavailable (clear sequence)
// BEHAVIOUR
//  Reset (rstn=0, async)
//   - ld_data=0, addr_err=0, every read-pipe stage=0.
//   - busy=1 when DMEM_CLEAR_EN is defined, otherwise 0.
//   - Array contents are not touched by reset itself.
//  Indexing
//   - idx = mem_addr[DEPTH_LOG2-1:0].
//   - oor = |mem_addr[ADDR_W-1:DEPTH_LOG2].
//  Write (posedge, !busy, !oor)
//   - For each k with we[k]=1: mem[idx][8k+:8] <= st_data[8k+:8].
//   - Lanes with we[k]=0 hold their value.
//   - we=0 means no write.
//  Read, every cycle, no read enable
//   - Stage 0 latches mem[idx].
//   - Stages 1..LOAD_LATENCY-1 are a plain shift.
//   - ld_data = last stage, so the address in cycle N gives ld_data in cycle N+LOAD_LATENCY.
//  Write-first
//   - A read and a write to the same idx in the same cycle latch the merged word.
//   - The merged word is the new lanes where we=1 and the old lanes elsewhere.
//  Ordering
//   - Once latched, a read is a snapshot.
//   - Later writes never alter data already in the pipe.
//  oor and busy on reads
//   - oor: write dropped; stage 0 latches 0; addr_err travels with the data (LOAD_LATENCY delay).
//   - busy: write dropped; stage 0 latches 0; addr_err=0.
//  Pipe timing
//   - The pipe keeps shifting through busy and oor cycles.
//   - Latency never stretches and there is no stall input.
// CONFIGURATION
//  DMEM_CLEAR_EN defined: clear FSM (dmem_state_t), states CLEAR and READY.
//   - Reset forces CLEAR, cnt=0, busy=1.
//   - CLEAR writes mem[cnt]=0 and increments cnt once per cycle.
//   - At cnt==DEPTH-1, CLEAR writes the final word and moves to READY in the next cycle.
//   - In READY, busy=0, so busy lasts exactly DEPTH cycles after reset release.
//   - Reset asserted mid-clear returns the FSM to CLEAR with cnt=0.
//   - In READY the FSM never re-enters CLEAR without reset.
//  DMEM_CLEAR_EN undefined: no FSM and no counter; busy is tied to 0.
//   - Contents are undefined until written.
// STRUCTURE
//  Shared package (common_params): reg_t, addr_t, REG_W, ADDR_W (existing); add DMEM_LANES=8 and dmem_state_t.
//  Sub-module dmem_read_pipe #(W, DEPTH=LOAD_LATENCY-1): async-reset delay line carrying {addr_err, data}.
//  Top level: array, lane merge, write-first bypass, oor/busy masking, optional clear FSM.
// TESTING
//  1 LL=1: write 0x1122334455667788 to idx 5 (we=ff); read idx 5 in the next cycle
//    -> ld_data=0x1122334455667788 one cycle after the address.
//  2 Partial write: we=0x0f, st_data=0xAAAAAAAA_BBBBBBBB to idx 5, then read
//    -> 0x11223344BBBBBBBB.
//  3 Same cycle: read and write idx 7 (old 0, we=0x01, st_data=0xFF)
//    -> ld_data=0x00000000000000FF (write-first).
//  4 mem_addr=2**DEPTH_LOG2, we=ff
//    -> ld_data=0 and addr_err=1 after LOAD_LATENCY cycles; a following read of idx 0 is unchanged.
//  5 LL=3: back-to-back reads of idx 1,2,3 holding 10,20,30
//    -> ld_data shows 10,20,30 on cycles N+3..N+5.
//  6 DMEM_CLEAR_EN, DEPTH_LOG2=4
//    -> busy high for exactly 16 cycles after rstn rises; writes in that window are dropped; all words read 0.
//    -> rstn pulsed at cycle 8 restarts the clear and busy stays high for 16 cycles from the new release.

Source files
------------

// File: rtl/common_params.sv
// Shared core parameters and types.
// Provides the register/address word types plus the data-memory lane count
// and the state encoding of the optional data-memory clear sequencer.
package common_params;

  localparam int unsigned REG_W      = 64;
  localparam int unsigned ADDR_W     = 61;
  localparam int unsigned DMEM_LANES = 8;

  typedef logic [REG_W-1:0]  reg_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dmem_state_t;

endpackage

// File: rtl/data_memory_if.sv
// Data-memory access bus between the execute-phase memory unit (master)
// and the data memory (slave).
//   mem_addr  word index (byte address >> 3)
//   st_data   store data already shifted onto its byte lanes
//   we        per-byte-lane write enable
//   ld_data   64-bit word returned LOAD_LATENCY cycles after its address
//   addr_err  out-of-range flag aligned with ld_data
//   busy      memory unavailable (clear sequence running)
interface data_memory_if;

  common_params::addr_t                        mem_addr;
  common_params::reg_t                         st_data;
  logic [common_params::DMEM_LANES-1:0]        we;
  common_params::reg_t                         ld_data;
  logic                                        addr_err;
  logic                                        busy;

  modport master (
    output mem_addr, st_data, we,
    input  ld_data, addr_err, busy
  );

  modport slave (
    input  mem_addr, st_data, we,
    output ld_data, addr_err, busy
  );

endinterface

// File: rtl/dmem_read_pipe.sv
// Async-reset delay line of DEPTH stages; DEPTH=0 is a straight wire.
// Ports: clk, rstn (async active-low), din (W bits in), dout (W bits out).
module dmem_read_pipe #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rstn;
    assign dout = din;
  end else begin : g_pipe
    logic [W-1:0] stage [DEPTH];

    // Plain shift; stage[0] takes din every cycle.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/data_memory.sv
// Data memory stage downstream of the execute-phase memory-access unit.
// Byte-lane writes, write-first reads, fixed LOAD_LATENCY read pipe with an
// out-of-range flag that travels alongside the data.
// Optional feature macro: DMEM_CLEAR_EN zero-fills the array after reset and
// holds busy high for exactly 2**DEPTH_LOG2 cycles.
// Ports:
//   clk   clock, all state on posedge
//   rstn  asynchronous active-low reset
//   bus   data_memory_if.slave (mem_addr, st_data, we in; ld_data, addr_err, busy out)
module data_memory
  import common_params::*;
#(
  parameter int unsigned LOAD_LATENCY = 1,
  parameter int unsigned DEPTH_LOG2   = 12
) (
  input  logic            clk,
  input  logic            rstn,
  data_memory_if.slave    bus
);

  localparam int unsigned DEPTH  = 2 ** DEPTH_LOG2;
  localparam int unsigned PIPE_W = REG_W + 1;

  typedef logic [DEPTH_LOG2-1:0] idx_t;

  reg_t              mem [DEPTH];
  idx_t              idx;
  logic              oor;
  logic              busy;
  logic              wr_en;
  reg_t              merged;
  logic              clr_we_c;
  idx_t              clr_idx;
  reg_t              s0_data;
  logic              s0_err;
  logic [PIPE_W-1:0] pipe_out;

  assign idx   = bus.mem_addr[DEPTH_LOG2-1:0];
  assign oor   = |bus.mem_addr[ADDR_W-1:DEPTH_LOG2];
  assign wr_en = !busy && !oor;

  // Old word with the enabled lanes replaced: both the stored value and the
  // write-first read result.
  always_comb begin
    merged = mem[idx];
    for (int unsigned k = 0; k < DMEM_LANES; k++) begin
      if (bus.we[k]) merged[8*k +: 8] = bus.st_data[8*k +: 8];
    end
  end

  // Array update: clear sequencer has priority, bus writes only when usable.
  always_ff @(posedge clk) begin
    if (clr_we_c) begin
      mem[clr_idx] <= '0;
    end else if (wr_en && |bus.we) begin
      mem[idx] <= merged;
    end
  end

  // Read stage 0: snapshot of the (merged) word; zero when busy or out of range.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s0_data <= '0;
      s0_err  <= 1'b0;
    end else begin
      s0_data <= wr_en ? merged : '0;
      s0_err  <= oor && !busy;
    end
  end

  dmem_read_pipe #(
    .W     (PIPE_W),
    .DEPTH (LOAD_LATENCY - 1)
  ) u_read_pipe (
    .clk  (clk),
    .rstn (rstn),
    .din  ({s0_err, s0_data}),
    .dout (pipe_out)
  );

  assign bus.ld_data  = pipe_out[REG_W-1:0];
  assign bus.addr_err = pipe_out[REG_W];
  assign bus.busy     = busy;

`ifdef DMEM_CLEAR_EN
  dmem_state_t state, state_next;
  idx_t        cnt, cnt_next;
  logic        busy_q, busy_next;

  // Clear sequencer state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= CLEAR;
      cnt    <= '0;
      busy_q <= 1'b1;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      busy_q <= busy_next;
    end
  end

  // One word zeroed per cycle; READY is terminal until reset.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    clr_we_c   = 1'b0;
    case (state)
      CLEAR: begin
        clr_we_c = 1'b1;
        cnt_next = cnt + idx_t'(1);
        if (cnt == idx_t'(DEPTH - 1)) state_next = READY;
      end
      READY:   state_next = READY;
      default: state_next = CLEAR;
    endcase
    busy_next = (state_next == CLEAR);
  end

  assign clr_idx = cnt;
  assign busy    = busy_q;
`else
  assign clr_we_c = 1'b0;
  assign clr_idx  = '0;
  assign busy     = 1'b0;
`endif

endmodule
